// File: rtl/cpu_core_v2.sv
// cpu_core_v2: 6502-subset core with tick divider, absolute/stack addressing and stall-on-not-valid reads.
// Build option CPU_DECIMAL_EN adds SED/CLD and packed-BCD ADC/SBC; without it the core is binary-only.
module cpu_core_v2 #(
  parameter int          CLOCK_DIVIDER = 12,
  parameter logic [15:0] RESET_VECTOR  = 16'hFFFC,
  parameter logic [7:0]  STACK_PAGE    = 8'h01
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic [7:0]  data_i,
  input  logic        data_valid_i,
  output logic [7:0]  data_o,
  output logic [15:0] address_o,
  output logic        address_valid_o,
  output logic        data_valid_o,
  output logic        sync_o
);
  localparam int DW = $clog2(CLOCK_DIVIDER) + 1;

  typedef enum logic [2:0] {
    S_RST_LO, S_RST_HI, S_FETCH, S_T1, S_T2, S_T3
  } state_t;

  state_t        state, state_nx;
  logic [DW-1:0] div;
  logic          tick, adv;
  logic [15:0]   pc, pc_nx, addr_nx;
  logic [7:0]    a, x, y, sp, p, ir, lo;
  logic [7:0]    a_nx, x_nx, y_nx, sp_nx, p_nx, ir_nx, lo_nx, wdata_nx;
  logic          we_nx, sync_nx, load_en;
  logic [7:0]    m, alu_r, alu_p;
  logic [8:0]    bin;

  assign address_valid_o = 1'b1;
  // Valid/ready: a tick retires the current bus cycle when it is a write (never stalls)
  // or a read with data_valid_i high; otherwise every register, address included, holds.
  assign adv = tick && (data_valid_o || data_valid_i);

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      div  <= '0;
      tick <= 1'b0;
    end else if (div == DW'(CLOCK_DIVIDER - 1)) begin
      div  <= '0;
      tick <= 1'b1;
    end else begin
      div  <= div + DW'(1);
      tick <= 1'b0;
    end
  end

`ifdef CPU_DECIMAL_EN
  logic [4:0] dlo, dhi;
  logic       hc;
`endif

  // N/Z/V always come from the binary sum; only the result and ADC carry change in decimal mode.
  always_comb begin
    m        = (ir == 8'hE9) ? ~data_i : data_i;
    bin      = {1'b0, a} + {1'b0, m} + {8'h00, p[0]};
    alu_r    = bin[7:0];
    alu_p    = p;
    alu_p[0] = bin[8];
    alu_p[1] = (bin[7:0] == 8'h00);
    alu_p[6] = ~(a[7] ^ m[7]) & (a[7] ^ bin[7]);
    alu_p[7] = bin[7];
`ifdef CPU_DECIMAL_EN
    hc  = 1'b0;
    dlo = {1'b0, a[3:0]} + {1'b0, m[3:0]} + {4'h0, p[0]};
    dhi = '0;
    if (p[3]) begin
      if (ir == 8'hE9) begin
        hc = dlo[4];
        if (!hc) dlo = dlo - 5'd6;
        dhi = {1'b0, a[7:4]} + {1'b0, m[7:4]} + {4'h0, hc};
        if (!dhi[4]) dhi = dhi - 5'd6;
      end else begin
        hc = (dlo > 5'd9);
        if (hc) dlo = dlo + 5'd6;
        dhi = {1'b0, a[7:4]} + {1'b0, m[7:4]} + {4'h0, hc};
        alu_p[0] = (dhi > 5'd9);
        if (dhi > 5'd9) dhi = dhi + 5'd6;
      end
      alu_r = {dhi[3:0], dlo[3:0]};
    end
`endif
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    a_nx     = a;
    x_nx     = x;
    y_nx     = y;
    sp_nx    = sp;
    p_nx     = p;
    ir_nx    = ir;
    lo_nx    = lo;
    addr_nx  = address_o;
    wdata_nx = data_o;
    we_nx    = 1'b0;
    sync_nx  = 1'b0;
    load_en  = 1'b0;
    unique case (state)
      S_RST_LO: begin
        pc_nx[7:0] = data_i;
        addr_nx    = RESET_VECTOR + 16'd1;
        state_nx   = S_RST_HI;
      end
      S_RST_HI: begin
        pc_nx[15:8] = data_i;
        state_nx    = S_FETCH;
      end
      S_FETCH: begin
        ir_nx    = data_i;
        pc_nx    = pc + 16'd1;
        addr_nx  = pc + 16'd1;
        state_nx = S_T1;
      end
      S_T1: begin
        state_nx = S_FETCH;
        case (ir)
          8'hA9, 8'hA2, 8'hA0: begin
            pc_nx   = pc + 16'd1;
            load_en = 1'b1;
          end
          8'h69, 8'hE9: begin
            pc_nx = pc + 16'd1;
            a_nx  = alu_r;
            p_nx  = alu_p;
          end
          8'hA5, 8'hA6, 8'hA4, 8'hB5, 8'h85: begin
            pc_nx    = pc + 16'd1;
            lo_nx    = data_i;
            addr_nx  = {8'h00, data_i};
            state_nx = S_T2;
            we_nx    = (ir == 8'h85);
            wdata_nx = a;
          end
          8'hAD, 8'hAE, 8'hAC, 8'h8D, 8'h4C: begin
            pc_nx    = pc + 16'd1;
            lo_nx    = data_i;
            addr_nx  = pc + 16'd1;
            state_nx = S_T2;
          end
          8'h48, 8'h68: begin
            addr_nx  = {STACK_PAGE, sp};
            we_nx    = (ir == 8'h48);
            wdata_nx = a;
            state_nx = S_T2;
          end
`ifdef CPU_DECIMAL_EN
          8'hF8:   p_nx[3] = 1'b1;
          8'hD8:   p_nx[3] = 1'b0;
`endif
          default: ;
        endcase
      end
      S_T2: begin
        state_nx = S_FETCH;
        case (ir)
          8'hA5, 8'hA6, 8'hA4: load_en = 1'b1;
          // Zero-page indexing wraps inside page zero.
          8'hB5: begin
            addr_nx  = {8'h00, lo + x};
            state_nx = S_T3;
          end
          8'hAD, 8'hAE, 8'hAC, 8'h8D: begin
            pc_nx    = pc + 16'd1;
            addr_nx  = {data_i, lo};
            we_nx    = (ir == 8'h8D);
            wdata_nx = a;
            state_nx = S_T3;
          end
          8'h4C:   pc_nx = {data_i, lo};
          8'h48:   sp_nx = sp - 8'd1;
          8'h68: begin
            sp_nx    = sp + 8'd1;
            addr_nx  = {STACK_PAGE, sp + 8'd1};
            state_nx = S_T3;
          end
          default: ;
        endcase
      end
      S_T3: begin
        state_nx = S_FETCH;
        load_en  = (ir != 8'h8D);
      end
      default: state_nx = S_RST_LO;
    endcase

    if (load_en) begin
      case (ir)
        8'hA2, 8'hA6, 8'hAE: x_nx = data_i;
        8'hA0, 8'hA4, 8'hAC: y_nx = data_i;
        default:             a_nx = data_i;
      endcase
      p_nx[7] = data_i[7];
      p_nx[1] = (data_i == 8'h00);
    end

    if (state_nx == S_FETCH) begin
      addr_nx = pc_nx;
      sync_nx = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state        <= S_RST_LO;
      pc           <= 16'h0000;
      a            <= 8'h00;
      x            <= 8'h00;
      y            <= 8'h00;
      sp           <= 8'hFD;
      p            <= 8'h34;
      ir           <= 8'h00;
      lo           <= 8'h00;
      address_o    <= RESET_VECTOR;
      data_o       <= 8'h00;
      data_valid_o <= 1'b0;
      sync_o       <= 1'b0;
    end else if (adv) begin
      state        <= state_nx;
      pc           <= pc_nx;
      a            <= a_nx;
      x            <= x_nx;
      y            <= y_nx;
      sp           <= sp_nx;
      p            <= p_nx;
      ir           <= ir_nx;
      lo           <= lo_nx;
      address_o    <= addr_nx;
      data_o       <= wdata_nx;
      data_valid_o <= we_nx;
      sync_o       <= sync_nx;
    end
  end
endmodule

// File: tb/tb_cpu_core_v2.sv
// Directed bench for cpu_core_v2: runs a fixed program from a bench memory and checks bus cycles,
// tick counts and architectural state against hand-computed values; a divide-by-3 copy checks tick pacing.
module tb_cpu_core_v2;
  logic        clock_i = 1'b0;
  logic        reset_ni;
  logic        data_valid_i;
  logic [7:0]  data_i, data_o;
  logic [15:0] address_o;
  logic        address_valid_o, data_valid_o, sync_o;
  logic [7:0]  data3_i, data3_o;
  logic [15:0] address3;
  logic        av3, dv3, sync3;

  logic [7:0]  mem [0:65535];
  logic [23:0] exp_q [$];
  logic [15:0] last_addr;
  logic [7:0]  exp_sum, exp_p_sed;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n;

  assign data_i  = mem[address_o];
  assign data3_i = mem[address3];

  cpu_core_v2 #(.CLOCK_DIVIDER(1)) dut (
    .clock_i(clock_i), .reset_ni(reset_ni), .data_i(data_i), .data_valid_i(data_valid_i),
    .data_o(data_o), .address_o(address_o), .address_valid_o(address_valid_o),
    .data_valid_o(data_valid_o), .sync_o(sync_o)
  );

  cpu_core_v2 #(.CLOCK_DIVIDER(3)) dut3 (
    .clock_i(clock_i), .reset_ni(reset_ni), .data_i(data3_i), .data_valid_i(1'b1),
    .data_o(data3_o), .address_o(address3), .address_valid_o(av3),
    .data_valid_o(dv3), .sync_o(sync3)
  );

  // clock / reset
  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [15:0] ad, input logic [7:0] b);
    mem[ad] = b;
  endtask

  // One system clock; the bench memory takes writes and the scoreboard checks them.
  task automatic step();
    logic [23:0] e;
    last_addr = address_o;
    @(negedge clock_i);
    if (data_valid_o) begin
      mem[address_o] = data_o;
      if (exp_q.size() == 0) check("wr_extra", 24'(exp_q.size()), 24'd1);
      else begin
        e = exp_q.pop_front();
        check("write", {address_o, data_o}, e);
      end
    end
  endtask

  task automatic run_to_fetch(input logic [15:0] target, input string tag, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!(sync_o && address_o == target) && cnt < 3000);
    check(tag, {7'd0, sync_o, address_o}, {8'h01, target});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_addr"}, {8'h00, address_o}, 24'h00FFFC);
    check({tag, "_bus"}, {20'h0, address_valid_o, data_valid_o, sync_o, 1'b0}, 24'h000008);
    check({tag, "_do"}, {16'h0, data_o}, 24'h0);
    check({tag, "_axy"}, {dut.a, dut.x, dut.y}, 24'h0);
    check({tag, "_sp_p"}, {8'h00, dut.sp, dut.p}, 24'h00FD34);
  endtask

  task automatic load_program();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    put(16'hFFFC, 8'h00); put(16'hFFFD, 8'h80);
    put(16'h007F, 8'hC3); put(16'h3000, 8'h81);
    put(16'h8000, 8'hA9); put(16'h8001, 8'h80); put(16'h8002, 8'h69); put(16'h8003, 8'h80);
    put(16'h8004, 8'hE9); put(16'h8005, 8'h00); put(16'h8006, 8'h85); put(16'h8007, 8'h10);
    put(16'h8008, 8'hA9); put(16'h8009, 8'h5A); put(16'h800A, 8'h8D); put(16'h800B, 8'h34);
    put(16'h800C, 8'h12); put(16'h800D, 8'hA9); put(16'h800E, 8'h00); put(16'h800F, 8'hAD);
    put(16'h8010, 8'h34); put(16'h8011, 8'h12); put(16'h8012, 8'h85); put(16'h8013, 8'h11);
    put(16'h8014, 8'hA2); put(16'h8015, 8'hFF); put(16'h8016, 8'hB5); put(16'h8017, 8'h80);
    put(16'h8018, 8'h85); put(16'h8019, 8'h12); put(16'h801A, 8'hA0); put(16'h801B, 8'h07);
    put(16'h801C, 8'hA6); put(16'h801D, 8'h20); put(16'h801E, 8'hAC); put(16'h801F, 8'h00);
    put(16'h8020, 8'h30); put(16'h8021, 8'h02); put(16'h8022, 8'hEA); put(16'h8023, 8'h4C);
    put(16'h8024, 8'h00); put(16'h8025, 8'h90);
    put(16'h9000, 8'hA9); put(16'h9001, 8'h00); put(16'h9002, 8'h69); put(16'h9003, 8'h00);
    put(16'h9004, 8'hF8); put(16'h9005, 8'hA9); put(16'h9006, 8'h19); put(16'h9007, 8'h69);
    put(16'h9008, 8'h28); put(16'h9009, 8'h85); put(16'h900A, 8'h13); put(16'h900B, 8'hD8);
    for (int i = 0; i < 254; i++) mem[16'h900C + i] = 8'h48;
    put(16'h910A, 8'hA9); put(16'h910B, 8'h00); put(16'h910C, 8'h68); put(16'h910D, 8'h85);
    put(16'h910E, 8'h14); put(16'h910F, 8'h4C); put(16'h9110, 8'hFE); put(16'h9111, 8'hFF);
    put(16'hFFFE, 8'hA9); put(16'hFFFF, 8'h77);
    put(16'h0000, 8'h85); put(16'h0001, 8'h15); put(16'h0002, 8'h4C); put(16'h0003, 8'h02);
    put(16'h0004, 8'h00);
  endtask

  initial begin
`ifdef CPU_DECIMAL_EN
    exp_sum   = 8'h47;
    exp_p_sed = 8'h3C;
`else
    exp_sum   = 8'h41;
    exp_p_sed = 8'h34;
`endif
    reset_ni     = 1'b0;
    data_valid_i = 1'b1;
    load_program();
    repeat (3) @(negedge clock_i);
    check_reset_state("rst");
    check("rst_tick_div", {22'h0, dut.tick, dut3.div[1]}, 24'h0);

    // boot sequence: divide-by-1 core fetches at 8000 in its third bus period
    reset_ni = 1'b1;
    step();
    check("boot_n1", {8'h00, address_o}, 24'h00FFFC);
    step();
    check("boot_n2", {8'h00, address_o}, 24'h00FFFD);
    step();
    check("boot_fetch", {7'd0, sync_o, address_o}, 24'h018000);
    check("div3_n3", {8'h00, address3}, 24'h00FFFC);
    step();
    check("div3_n4", {8'h00, address3}, 24'h00FFFD);
    step();
    check("lda80_fetch", {7'd0, sync_o, address_o}, 24'h018002);
    check("lda80_ap", {8'h00, dut.a, dut.p}, 24'h0080B4);
    step();
    check("div3_n6", {8'h00, address3}, 24'h00FFFD);
    step();
    check("div3_fetch", {7'd0, sync3, address3}, 24'h018000);
    check("adc_fetch", {7'd0, sync_o, address_o}, 24'h018004);
    check("adc_ap", {8'h00, dut.a, dut.p}, 24'h000077);

    run_to_fetch(16'h8006, "f8006", n);
    check("sbc_ticks", 24'(n), 24'd2);
    check("sbc_ap", {8'h00, dut.a, dut.p}, 24'h000037);
    exp_q.push_back(24'h001000);
    run_to_fetch(16'h8008, "f8008", n);
    check("sta_zp_ticks", 24'(n), 24'd3);
    run_to_fetch(16'h800A, "f800a", n);
    exp_q.push_back(24'h12345A);
    run_to_fetch(16'h800D, "f800d", n);
    check("sta_abs_ticks", 24'(n), 24'd4);
    run_to_fetch(16'h800F, "f800f", n);

    // stall the high-operand read of LDA $1234 for five ticks
    step();
    step();
    check("stall_at", {8'h00, address_o}, 24'h008011);
    data_valid_i = 1'b0;
    repeat (5) step();
    check("stall_hold", {7'd0, sync_o, address_o}, 24'h008011);
    data_valid_i = 1'b1;
    run_to_fetch(16'h8012, "f8012", n);
    check("stall_ticks", 24'(7 + n), 24'd9);
    check("lda_abs_addr", {8'h00, last_addr}, 24'h001234);
    check("lda_abs_a", {16'h0, dut.a}, 24'h00005A);

    exp_q.push_back(24'h00115A);
    run_to_fetch(16'h8014, "f8014", n);
    run_to_fetch(16'h8016, "f8016", n);
    check("ldx_imm", {16'h0, dut.x}, 24'h0000FF);
    run_to_fetch(16'h8018, "f8018", n);
    check("zpx_ticks", 24'(n), 24'd4);
    check("zpx_addr", {8'h00, last_addr}, 24'h00007F);
    check("zpx_ap", {8'h00, dut.a, dut.p}, 24'h00C3B5);
    exp_q.push_back(24'h0012C3);
    run_to_fetch(16'h801A, "f801a", n);
    run_to_fetch(16'h801C, "f801c", n);
    check("ldy_imm", {16'h0, dut.y}, 24'h000007);
    run_to_fetch(16'h801E, "f801e", n);
    check("ldx_zp", {24'(n), dut.x, dut.p}, 24'h030037);
    check("ldx_zp_addr", {8'h00, last_addr}, 24'h000020);
    run_to_fetch(16'h8021, "f8021", n);
    check("ldy_abs", {24'(n), dut.y, dut.p}, 24'h0481B5);
    check("ldy_abs_addr", {8'h00, last_addr}, 24'h003000);
    run_to_fetch(16'h8022, "f8022", n);
    check("unknown_ticks", 24'(n), 24'd2);
    run_to_fetch(16'h8023, "f8023", n);
    check("nop_ticks", 24'(n), 24'd2);
    run_to_fetch(16'h9000, "jmp_target", n);
    check("jmp_ticks", 24'(n), 24'd3);

    run_to_fetch(16'h9002, "f9002", n);
    run_to_fetch(16'h9004, "f9004", n);
    check("adc_clc_ap", {8'h00, dut.a, dut.p}, 24'h000134);
    run_to_fetch(16'h9005, "f9005", n);
    check("sed", {24'(n), dut.p}, {16'h0002, exp_p_sed});
    run_to_fetch(16'h9007, "f9007", n);
    run_to_fetch(16'h9009, "f9009", n);
    check("bcd_ap", {8'h00, dut.a, dut.p}, {8'h00, exp_sum, exp_p_sed});
    exp_q.push_back({16'h0013, exp_sum});
    run_to_fetch(16'h900B, "f900b", n);
    run_to_fetch(16'h900C, "f900c", n);
    check("cld_p", {16'h0, dut.p}, 24'h000034);

    // 254 pushes: the 253rd reaches SP=00, the last writes 0100 and wraps SP to FF
    for (int i = 0; i < 254; i++) exp_q.push_back({8'h01, 8'(253 - i), exp_sum});
    run_to_fetch(16'h910A, "f910a", n);
    check("pha_ticks", 24'(n), 24'd762);
    check("pha_wrap", {last_addr, dut.sp}, 24'h0100FF);
    run_to_fetch(16'h910C, "f910c", n);
    check("lda_clear", {16'h0, dut.a}, 24'h0);
    run_to_fetch(16'h910D, "f910d", n);
    check("pla", {24'(n), dut.a, dut.sp}, {8'h04, exp_sum, 8'h00});
    check("pla_addr", {8'h00, last_addr}, 24'h000100);
    exp_q.push_back({16'h0014, exp_sum});
    run_to_fetch(16'h910F, "f910f", n);
    run_to_fetch(16'hFFFE, "fffe", n);
    run_to_fetch(16'h0000, "pc_wrap", n);
    check("pc_wrap_a", {16'h0, dut.a}, 24'h000077);
    exp_q.push_back(24'h001577);
    run_to_fetch(16'h0002, "f0002", n);

    // re-run from reset and abort an STA in its write period
    reset_ni = 1'b0;
    step();
    step();
    check_reset_state("rst2");
    reset_ni = 1'b1;
    exp_q.push_back(24'h001000);
    exp_q.push_back(24'h12345A);
    run_to_fetch(16'h8012, "rerun_8012", n);
    exp_q.push_back(24'h00115A);
    step();
    step();
    check("abort_in_write", {23'h0, data_valid_o}, 24'h1);
    reset_ni = 1'b0;
    step();
    check("abort_strobe", {7'h0, data_valid_o, data_o, 8'h00}, 24'h0);
    check("abort_addr", {7'd0, sync_o, address_o}, 24'h00FFFC);
    check("wr_missing", 24'(exp_q.size()), 24'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
